// File: rtl/blasys_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module  : blasys_sweep_pkg
// Brief   : Sweep FSM state encoding and accumulator width helpers.
// Rev     : 1.0  initial release
// ============================================================================
package blasys_sweep_pkg;

  typedef enum logic [1:0] {
    c_idle  = 2'd0,
    c_sweep = 2'd1,
    c_drain = 2'd2,
    c_done  = 2'd3
  } sweep_state_t;

  // Up to 2^NUM_PI mismatching vectors must be countable.
  function automatic int err_cnt_w(input int num_pi);
    return num_pi + 1;
  endfunction

  // 2^NUM_PI vectors times up to 16 differing bits each.
  function automatic int hd_sum_w(input int num_pi);
    return num_pi + 5;
  endfunction

  function automatic int pop_w(input int num_po);
    return $clog2(num_po + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/partition_err_acc.sv
`default_nettype none
// ============================================================================
// Module  : partition_err_acc
// Brief   : Per-vector exact/approx compare, popcount and metric accumulation.
//           Max |exact-approx| tracking exists only when MAX_ABS_ERR_EN is
//           defined; otherwise max_abs_err is tied to 0.
// Rev     : 1.0  initial release
// ============================================================================
module partition_err_acc
  import blasys_sweep_pkg::*;
#(
  parameter int NUM_PI = 7,
  parameter int NUM_PO = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           vld,
  input  logic [NUM_PO-1:0]              po_exact,
  input  logic [NUM_PO-1:0]              po_approx,
  output logic [err_cnt_w(NUM_PI)-1:0]   err_count,
  output logic [hd_sum_w(NUM_PI)-1:0]    hd_sum,
  output logic [NUM_PO-1:0]              max_abs_err
);

  localparam int c_err_w = err_cnt_w(NUM_PI);
  localparam int c_hd_w  = hd_sum_w(NUM_PI);
  localparam int c_pop_w = pop_w(NUM_PO);

  logic [NUM_PO-1:0]  w_diff;
  logic               w_mis;
  logic [c_pop_w-1:0] w_pop;
  logic [c_err_w-1:0] r_err_count;
  logic [c_hd_w-1:0]  r_hd_sum;

  assign w_diff = po_exact ^ po_approx;
  assign w_mis  = |w_diff;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_PO; i++) begin
      w_pop = w_pop + c_pop_w'(w_diff[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_err_count <= '0;
      r_hd_sum    <= '0;
    end else if (vld) begin
      r_err_count <= r_err_count + c_err_w'(w_mis);
      r_hd_sum    <= r_hd_sum + c_hd_w'(w_pop);
    end
  end

  assign err_count = r_err_count;
  assign hd_sum    = r_hd_sum;

`ifdef MAX_ABS_ERR_EN
  logic [NUM_PO-1:0] w_abs;
  logic [NUM_PO-1:0] r_max_abs_err;

  assign w_abs = (po_exact > po_approx) ? (po_exact - po_approx)
                                        : (po_approx - po_exact);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_max_abs_err <= '0;
    end else if (vld && (w_abs > r_max_abs_err)) begin
      r_max_abs_err <= w_abs;
    end
  end

  assign max_abs_err = r_max_abs_err;
`else
  assign max_abs_err = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/partition_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module  : partition_sweep_checker
// Brief   : Exhaustively sweeps a partition's inputs and accumulates error
//           metrics between exact and approximate responses. Optional macro
//           MAX_ABS_ERR_EN enables max |exact-approx| tracking.
// Rev     : 1.0  initial release
// ============================================================================
module partition_sweep_checker
  import blasys_sweep_pkg::*;
#(
  parameter int NUM_PI  = 7,
  parameter int NUM_PO  = 4,
  parameter int DUT_LAT = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [NUM_PI-1:0]              pi,
  input  logic [NUM_PO-1:0]              po_exact,
  input  logic [NUM_PO-1:0]              po_approx,
  output logic                           busy,
  output logic                           done,
  output logic [err_cnt_w(NUM_PI)-1:0]   err_count,
  output logic [hd_sum_w(NUM_PI)-1:0]    hd_sum,
  output logic [NUM_PO-1:0]              max_abs_err
);

  localparam logic [NUM_PI-1:0] c_last_vec   = '1;
  localparam logic [2:0]        c_drain_last = 3'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

  sweep_state_t      r_state;
  logic [NUM_PI-1:0] r_pi;
  logic              r_busy;
  logic              r_done;
  logic [2:0]        r_dcnt;
  logic              w_start_acc;
  logic              w_sweep_vld;
  logic              w_cmp_vld;

  assign w_start_acc = (r_state == c_idle) && start;
  assign w_sweep_vld = (r_state == c_sweep);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
      r_pi    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start) begin
            r_state <= c_sweep;
            r_pi    <= '0;
            r_busy  <= 1'b1;
          end
        end
        c_sweep: begin
          // pi parks on all-ones after the last vector rather than wrapping.
          if (r_pi == c_last_vec) begin
            if (DUT_LAT == 0) begin
              r_state <= c_done;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= c_drain;
              r_dcnt  <= '0;
            end
          end else begin
            r_pi <= r_pi + NUM_PI'(1);
          end
        end
        c_drain: begin
          if (r_dcnt == c_drain_last) begin
            r_state <= c_done;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 3'd1;
          end
        end
        c_done: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  // Valid tags travel alongside the partition latency so each response is
  // scored exactly when it arrives.
  generate
    if (DUT_LAT == 0) begin : g_no_pipe
      assign w_cmp_vld = w_sweep_vld;
    end else begin : g_vld_pipe
      logic [DUT_LAT-1:0] r_vld_pipe;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld_pipe <= '0;
        end else begin
          r_vld_pipe <= (r_vld_pipe << 1) | DUT_LAT'(w_sweep_vld);
        end
      end
      assign w_cmp_vld = r_vld_pipe[DUT_LAT-1];
    end
  endgenerate

  partition_err_acc #(
    .NUM_PI (NUM_PI),
    .NUM_PO (NUM_PO)
  ) u_err_acc (
    .clk         (clk),
    .rst         (rst),
    .clr         (w_start_acc),
    .vld         (w_cmp_vld),
    .po_exact    (po_exact),
    .po_approx   (po_approx),
    .err_count   (err_count),
    .hd_sum      (hd_sum),
    .max_abs_err (max_abs_err)
  );

  assign pi   = r_pi;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_partition_sweep_checker.sv
`timescale 1ns/1ps
`default_nettype none
// Bench: a zero-latency and a two-cycle-latency checker swept side by side
// against behavioural partition models, scored by a queue-based monitor.
module tb_partition_sweep_checker;

  localparam int NV = 128;

  typedef struct {
    int          t0;
    int          t_done;
    logic [7:0]  err;
    logic [11:0] hd;
    logic [3:0]  mx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  pi0, pi2;
  logic [3:0]  pe0, pa0, pe2, pa2, pe2_d, pa2_d;
  logic        busy0, done0, busy2, done2;
  logic [7:0]  err0, err2;
  logic [11:0] hd0, hd2;
  logic [3:0]  mx0, mx2;

  int         mode = 0;
  logic [3:0] tbl_e [NV];
  logic [3:0] tbl_a [NV];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  exp_t       q0[$];
  exp_t       q2[$];
  logic [7:0]  cur_e;
  logic [11:0] cur_h;
  logic [3:0]  cur_m;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] f_exact(input int m, input logic [6:0] p);
    case (m)
      0:       return p[3:0] ^ p[6:3];
      1:       return p[3:0];
      default: return tbl_e[p];
    endcase
  endfunction

  function automatic logic [3:0] f_approx(input int m, input logic [6:0] p);
    case (m)
      0:       return f_exact(m, p);
      1:       return p[3:0] & 4'b1110;
      2:       return ~tbl_e[p];
      default: return tbl_a[p];
    endcase
  endfunction

  always_comb begin
    pe0 = f_exact(mode, pi0);
    pa0 = f_approx(mode, pi0);
  end

  always @(posedge clk) begin
    pe2_d <= f_exact(mode, pi2);
    pa2_d <= f_approx(mode, pi2);
    pe2   <= pe2_d;
    pa2   <= pa2_d;
  end

  partition_sweep_checker #(.NUM_PI(7), .NUM_PO(4), .DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .pi(pi0), .po_exact(pe0), .po_approx(pa0),
    .busy(busy0), .done(done0), .err_count(err0), .hd_sum(hd0), .max_abs_err(mx0)
  );

  partition_sweep_checker #(.NUM_PI(7), .NUM_PO(4), .DUT_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .pi(pi2), .po_exact(pe2), .po_approx(pa2),
    .busy(busy2), .done(done2), .err_count(err2), .hd_sum(hd2), .max_abs_err(mx2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Metrics straight from the definitions over the full vector space.
  function automatic void ref_model(input int m, output logic [7:0] e,
                                    output logic [11:0] h, output logic [3:0] mx);
    int ia, ib, d;
    logic [3:0] a, b;
    e = '0; h = '0; mx = '0;
    for (int k = 0; k < NV; k++) begin
      a  = f_exact(m, 7'(k));
      b  = f_approx(m, 7'(k));
      ia = int'(a);
      ib = int'(b);
      if (a != b) e = e + 8'd1;
      h  = h + 12'($countones(a ^ b));
      d  = (ia > ib) ? ia - ib : ib - ia;
      if (d > int'(mx)) mx = 4'(d);
    end
`ifndef MAX_ABS_ERR_EN
    mx = '0;
`endif
  endfunction

  task automatic mon(input int id, input string tag, input logic d, input logic b,
                     input logic [6:0] p, input logic [7:0] e, input logic [11:0] h,
                     input logic [3:0] m);
    exp_t x;
    bit   have;
    if (id == 0) begin
      have = q0.size() != 0;
      if (have) x = q0[0];
    end else begin
      have = q2.size() != 0;
      if (have) x = q2[0];
    end
    if (d) begin
      if (!have) check({tag, "_unexpected_done"}, 1, 0);
      else begin
        check({tag, "_done_cycle"}, cyc, x.t_done);
        check({tag, "_busy_at_done"}, b, 0);
        check({tag, "_err_count"}, e, x.err);
        check({tag, "_hd_sum"}, h, x.hd);
        check({tag, "_max_abs_err"}, m, x.mx);
        if (id == 0) void'(q0.pop_front());
        else void'(q2.pop_front());
      end
    end else if (have) begin
      if (cyc >= x.t_done) begin
        check({tag, "_done_timeout"}, 0, 1);
        if (id == 0) void'(q0.pop_front());
        else void'(q2.pop_front());
      end else if (cyc > x.t0) begin
        check({tag, "_busy"}, b, 1);
        if (cyc <= x.t0 + NV) check({tag, "_pi_seq"}, p, cyc - x.t0 - 1);
      end
    end
  endtask

  always @(negedge clk) mon(0, "lat0", done0, busy0, pi0, err0, hd0, mx0);
  always @(negedge clk) mon(2, "lat2", done2, busy2, pi2, err2, hd2, mx2);

  task automatic check_idle(input string tag, input logic b, input logic d, input logic [6:0] p,
                            input logic [7:0] e, input logic [11:0] h, input logic [3:0] m);
    check({tag, "_idle_busy"}, b, 0);
    check({tag, "_idle_done"}, d, 0);
    check({tag, "_idle_pi"}, p, 0);
    check({tag, "_idle_metrics"}, {12'(e), h, 4'(m)}, 0);
  endtask

  task automatic fill_tables();
    for (int k = 0; k < NV; k++) begin
      tbl_e[k] = 4'($urandom);
      tbl_a[k] = 4'($urandom);
    end
  endtask

  // Called at a negedge; that cycle becomes t0 for both checkers.
  task automatic issue(input int m, output int t0);
    exp_t x;
    mode = m;
    ref_model(m, cur_e, cur_h, cur_m);
    t0       = cyc;
    x.t0     = t0;
    x.err    = cur_e;
    x.hd     = cur_h;
    x.mx     = cur_m;
    x.t_done = t0 + NV + 1;
    q0.push_back(x);
    x.t_done = t0 + NV + 3;
    q2.push_back(x);
    start0 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic run_sweep(input int m, input bit glitch);
    int t0;
    int tg;
    issue(m, t0);
    if (glitch) begin
      while (cyc < t0 + 10) @(negedge clk);
      start0 = 1'b1; start2 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start2 = 1'b0;
      tg = $urandom_range(t0 + 12, t0 + NV - 1);
      while (cyc < tg) @(negedge clk);
      start0 = 1'b1; start2 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start2 = 1'b0;
      // Pulse each checker's start while it sits in DONE.
      while (cyc < t0 + NV + 1) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      while (cyc < t0 + NV + 3) @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
    end
    while (cyc < t0 + NV + 4) @(negedge clk);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    check("lat0_ignored_start", busy0, 0);
    check("lat2_ignored_start", busy2, 0);
    check("lat0_hold", {err0, hd0, mx0}, {cur_e, cur_h, cur_m});
    check("lat2_hold", {err2, hd2, mx2}, {cur_e, cur_h, cur_m});
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    check_idle("lat0_reset", busy0, done0, pi0, err0, hd0, mx0);
    check_idle("lat2_reset", busy2, done2, pi2, err2, hd2, mx2);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    fill_tables();
    run_sweep(2, 1'b0);
    fill_tables();
    run_sweep(3, 1'b1);

    // Mid-sweep reset while pi == 50.
    fill_tables();
    issue(2, t0);
    while (cyc < t0 + 51) @(negedge clk);
    check("lat0_pi_before_rst", pi0, 50);
    rst = 1'b1;
    q0.delete();
    q2.delete();
    @(negedge clk);
    rst = 1'b0;
    check_idle("lat0_midrst", busy0, done0, pi0, err0, hd0, mx0);
    check_idle("lat2_midrst", busy2, done2, pi2, err2, hd2, mx2);
    repeat (NV + 10) @(negedge clk);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start0 = 1'b1; start2 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start0 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    check("lat0_rst_priority", busy0, 0);
    check("lat2_rst_priority", busy2, 0);

    run_sweep(2, 1'b0);
    for (int r = 0; r < 3; r++) begin
      fill_tables();
      run_sweep($urandom_range(0, 3), 1'(r & 1));
    end
    repeat (4) @(negedge clk);
    check("lat0_pending", q0.size(), 0);
    check("lat2_pending", q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
